bcd_countdown_ctrl: RTL

//  Sequences one shared 2-digit BCD subtractor (combinational, diff = A - B) to run an MM:SS countdown.

---
 rtl/bcd_countdown_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/bcd_countdown_ctrl.sv
// bcd_countdown_ctrl: MM:SS countdown that time-shares one external 2-digit BCD subtractor,
// spending one subtract cycle per 1 Hz tick on either the seconds or the minutes field.
module bcd_countdown_ctrl #(
   parameter logic [7:0] SEC_WRAP = 8'h59,
   parameter logic [7:0] MIN_MAX  = 8'h99,
   parameter logic [7:0] DEC_STEP = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       tick,
   input  logic [7:0] sub_diff,
   output logic [7:0] sub_a,
   output logic [7:0] sub_b,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done
);
   typedef enum logic [2:0] {IDLE, RUN, SUB_SEC, SUB_MIN, PAUSED, DONE} state_t;
   state_t     state_q, state_d;
   logic [7:0] min_q, min_d, sec_q, sec_d, sub_a_q, sub_a_d, sub_b_q, sub_b_d;
   logic       pend_tick_q, pend_tick_d, pend_pause_q, pend_pause_d;
   logic       zero, tick_eff;
   function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [3:0] tens_max,
                                            input logic [7:0] lim);
      logic [7:0] c;
      c = {(v[7:4] > tens_max) ? tens_max : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
      return (c > lim) ? lim : c;
   endfunction
   assign zero     = (min_q == 8'h00) && (sec_q == 8'h00);
   assign tick_eff = tick | pend_tick_q;
   always_comb begin
      state_d      = state_q;
      min_d        = min_q;
      sec_d        = sec_q;
      sub_a_d      = 8'h00;
      sub_b_d      = 8'h00;
      pend_tick_d  = pend_tick_q;
      pend_pause_d = pend_pause_q;
      case (state_q)
         IDLE, PAUSED, DONE: begin
            if (load) begin
               min_d       = clamp_bcd(load_min, 4'd9, MIN_MAX);
               sec_d       = clamp_bcd(load_sec, 4'd5, SEC_WRAP);
               pend_tick_d = 1'b0;
               state_d     = (state_q == DONE) ? IDLE : state_q;
            end else if (start && !pause && state_q != DONE) begin
               state_d = zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (tick_eff) begin
               // a fresh tick arriving while the pending one is serviced takes its slot
               pend_tick_d  = tick & pend_tick_q;
               pend_pause_d = pause;
               sub_b_d      = DEC_STEP;
               if (sec_q != 8'h00) begin
                  state_d = SUB_SEC;
                  sub_a_d = sec_q;
               end else begin
                  state_d = SUB_MIN;
                  sec_d   = SEC_WRAP;
                  sub_a_d = min_q;
               end
            end else if (pause) begin
               state_d = PAUSED;
            end
         end
         SUB_SEC, SUB_MIN: begin
            if (state_q == SUB_SEC) sec_d = sub_diff;
            else min_d = sub_diff;
            pend_pause_d = 1'b0;
            if (min_d == 8'h00 && sec_d == 8'h00) begin
               state_d     = DONE;
               pend_tick_d = 1'b0;
            end else begin
               pend_tick_d = pend_tick_q | tick;
               state_d     = (pend_pause_q | pause) ? PAUSED : RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         min_q        <= 8'h00;
         sec_q        <= 8'h00;
         sub_a_q      <= 8'h00;
         sub_b_q      <= 8'h00;
         pend_tick_q  <= 1'b0;
         pend_pause_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         sub_a_q      <= sub_a_d;
         sub_b_q      <= sub_b_d;
         pend_tick_q  <= pend_tick_d;
         pend_pause_q <= pend_pause_d;
      end
   end
   assign sub_a   = sub_a_q;
   assign sub_b   = sub_b_q;
   assign min_bcd = min_q;
   assign sec_bcd = sec_q;
   assign running = (state_q == RUN) || (state_q == SUB_SEC) || (state_q == SUB_MIN);
   assign done    = (state_q == DONE);
endmodule
